apb4_master_mux: RTL and testbench
==================================

// Module: apb4_master_mux
// PURPOSE
//  Parametrised APB4 requester: takes single-beat commands over a valid/ready port,
//  decodes the address to one of NUM_SLAVES PSEL lines and runs IDLE/SETUP/ACCESS.
//  Muxes per-slave PREADY/PRDATA/PSLVERR, adds a wait-state timeout, returns a response pulse.
//  Sits between the bus bridge/CPU port and the peripheral APB segment.
// PARAMETERS
//  ADDR_WIDTH   32  PADDR / cmd_addr width
//  DATA_WIDTH   32  PWDATA/PRDATA width (8/16/32); PSTRB width = DATA_WIDTH/8
//  NUM_SLAVES   4   PSEL lines (1..16); SW = max(1,clog2(NUM_SLAVES))
//  SLV_LSB      12  slave index = cmd_addr[SLV_LSB +: SW]
//  TIMEOUT      16  max ACCESS cycles with PREADY low before abort; 0 = no timeout
// PORTS
//  PCLK         in   1                  clock, all logic on rising edge
//  PRESETn      in   1                  reset, synchronous, active-low
//  cmd_valid    in   1                  command present
//  cmd_ready    out  1                  command accepted when valid&&ready
//  cmd_addr     in   ADDR_WIDTH         transfer address
//  cmd_write    in   1                  1=write, 0=read
//  cmd_wdata    in   DATA_WIDTH         write data
//  cmd_strb     in   DATA_WIDTH/8       write byte strobes
//  cmd_prot     in   3                  PPROT value
//  rsp_valid    out  1                  one-cycle response pulse
//  rsp_rdata    out  DATA_WIDTH         read data (0 for writes/errors)
//  rsp_err      out  1                  PSLVERR, decode error or timeout
//  rsp_timeout  out  1                  error was a timeout
//  PADDR        out  ADDR_WIDTH         APB address
//  PPROT        out  3                  APB protection
//  PSEL         out  NUM_SLAVES         one-hot select
//  PENABLE      out  1                  APB enable
//  PWRITE       out  1                  APB direction
//  PWDATA       out  DATA_WIDTH         APB write data
//  PSTRB        out  DATA_WIDTH/8       APB strobes
//  PREADY       in   NUM_SLAVES         per-slave ready
//  PRDATA       in   NUM_SLAVES*DATA_WIDTH per-slave read data, slave i at [i*DW +: DW]
//  PSLVERR      in   NUM_SLAVES         per-slave error
// BEHAVIOUR
//  - Reset (PRESETn low at edge): state IDLE; every output 0; counter 0; in-flight transfer dropped, no rsp.
//  - All APB and rsp outputs registered. cmd_ready combinational: 1 in IDLE, or in ACCESS when
//    selected PREADY=1 (completion cycle); 0 otherwise.
//  - States IDLE, SETUP, ACCESS, DERR.
//  - IDLE: accept -> capture addr/write/wdata/prot; PSTRB=cmd_strb on write, 0 on read.
//    idx<NUM_SLAVES -> SETUP (PSEL[idx]=1, PENABLE=0); idx>=NUM_SLAVES -> DERR, no PSEL.
//  - SETUP: exactly one cycle -> ACCESS, PENABLE=1; PADDR/PWRITE/PWDATA/PSTRB/PPROT/PSEL held stable.
//  - ACCESS: sample PREADY[idx]. 1 -> rsp_valid=1 next cycle, rsp_rdata=PRDATA[idx] on read
//    (0 on write), rsp_err=PSLVERR[idx]; no cmd_valid -> IDLE, all APB outputs 0;
//    cmd_valid -> back-to-back into SETUP/DERR for the new command with no IDLE cycle.
//  - Latency: accept at edge T -> SETUP T+1 -> ACCESS T+2 -> rsp_valid T+3 with zero wait states.
//  - Timeout (TIMEOUT>0): counter clears on SETUP entry, +1 per ACCESS cycle with PREADY low. At
//    TIMEOUT -> PSEL/PENABLE 0, IDLE, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//    PREADY=1 on that cycle wins: normal completion. Counter saturates, never wraps.
//  - DERR: one cycle, rsp_valid=1, rsp_err=1, rsp_rdata=0 next cycle, then IDLE; cmd_ready=0.
//  - PREADY/PRDATA/PSLVERR of unselected slaves ignored. rsp_* are 0 whenever rsp_valid=0.
// TESTING
//  1 Write 0x0000_1004 data 0xDEADBEEF strb 0xF, PREADY[1]=1 -> PSEL=4'b0010, PENABLE at T+2,
//    rsp_valid T+3 rsp_err=0.
//  2 Read 0x0000_3000, PREADY[3] low 3 cycles, PRDATA[3]=0x12345678 -> PENABLE held 4 cycles,
//    rsp_rdata=0x12345678, PSTRB=0.
//  3 Two commands back-to-back (cmd_valid held) -> SETUP follows completing ACCESS directly,
//    PENABLE low exactly one cycle between.
//  4 PREADY[0] never high, TIMEOUT=16 -> abort after 16 ACCESS cycles, rsp_err=1 rsp_timeout=1,
//    PSEL=0.
//  5 NUM_SLAVES=3, addr idx 3 -> no PSEL asserted, rsp_err=1 two cycles after accept;
//    PSLVERR[2]=1 on slave 2 -> rsp_err=1, rsp_timeout=0.
//  6 PRESETn low during ACCESS -> next edge all outputs 0, no rsp_valid; next command runs normally.

Source files
------------

// File: rtl/apb4_master_mux.sv
`default_nettype none
// ============================================================================
//  Module      : apb4_master_mux
//  Description : APB4 requester. Accepts single-beat commands on a valid/ready
//                port, decodes the address to one of NUM_SLAVES PSEL lines,
//                runs SETUP/ACCESS with a wait-state timeout and returns a
//                one-cycle response pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb4_master_mux #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SLV_LSB    = 12,
    parameter int TIMEOUT    = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESETn,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [ADDR_WIDTH-1:0]            cmd_addr,
    input  logic                             cmd_write,
    input  logic [DATA_WIDTH-1:0]            cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]          cmd_strb,
    input  logic [2:0]                       cmd_prot,
    output logic                             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             rsp_timeout,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [2:0]                       PPROT,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [DATA_WIDTH/8-1:0]          PSTRB,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PSLVERR
);

    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int SB = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_LIM = CW'(TIMEOUT);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DERR   = 2'd3;

    logic [1:0]            state, state_nxt;
    logic [SW-1:0]         cmd_idx;
    logic [NUM_SLAVES-1:0] cmd_dec;
    logic                  cmd_dec_ok;
    logic                  accept;
    logic                  sel_ready, sel_err;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic [CW-1:0]         cnt, cnt_inc, cnt_nxt;
    logic                  tmo_hit;

    logic [ADDR_WIDTH-1:0] paddr_nxt;
    logic [2:0]            pprot_nxt;
    logic [NUM_SLAVES-1:0] psel_nxt;
    logic                  penable_nxt, pwrite_nxt;
    logic [DATA_WIDTH-1:0] pwdata_nxt;
    logic [SB-1:0]         pstrb_nxt;
    logic                  rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
    logic [DATA_WIDTH-1:0] rsp_rdata_nxt;

    assign cmd_idx = cmd_addr[SLV_LSB +: SW];

    // One-hot decode of the command's slave index; out-of-range indices decode to nothing
    always_comb begin
        cmd_dec = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (cmd_idx == SW'(i)) cmd_dec[i] = 1'b1;
        end
        cmd_dec_ok = |cmd_dec;
    end

    // Response mux driven by the registered PSEL, so unselected slaves never contribute
    always_comb begin
        sel_ready = |(PREADY & PSEL);
        sel_err   = |(PSLVERR & PSEL);
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (PSEL[i]) sel_rdata = sel_rdata | PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Saturating wait-state counter increment and timeout detection on the current ACCESS cycle
    always_comb begin
        cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
        tmo_hit = (TIMEOUT > 0) && !sel_ready && (cnt_inc >= TMO_LIM);
    end

    assign cmd_ready = PRESETn && ((state == ST_IDLE) || ((state == ST_ACCESS) && sel_ready));
    assign accept    = cmd_valid && cmd_ready;

    // State register
    always_ff @(posedge PCLK) begin
        if (!PRESETn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; a completing ACCESS chains straight into the next command
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (cmd_valid) state_nxt = cmd_dec_ok ? ST_SETUP : ST_DERR;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (sel_ready) begin
                    if (cmd_valid) state_nxt = cmd_dec_ok ? ST_SETUP : ST_DERR;
                    else           state_nxt = ST_IDLE;
                end else if (tmo_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DERR:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Next values for the registered APB and response outputs
    always_comb begin
        paddr_nxt       = PADDR;
        pprot_nxt       = PPROT;
        psel_nxt        = PSEL;
        penable_nxt     = PENABLE;
        pwrite_nxt      = PWRITE;
        pwdata_nxt      = PWDATA;
        pstrb_nxt       = PSTRB;
        cnt_nxt         = cnt;
        rsp_valid_nxt   = 1'b0;
        rsp_rdata_nxt   = '0;
        rsp_err_nxt     = 1'b0;
        rsp_timeout_nxt = 1'b0;
        case (state)
            ST_SETUP:  penable_nxt = 1'b1;
            ST_ACCESS: begin
                if (sel_ready || tmo_hit) begin
                    rsp_valid_nxt = 1'b1;
                    paddr_nxt     = '0;
                    pprot_nxt     = '0;
                    psel_nxt      = '0;
                    penable_nxt   = 1'b0;
                    pwrite_nxt    = 1'b0;
                    pwdata_nxt    = '0;
                    pstrb_nxt     = '0;
                end
                if (sel_ready) begin
                    rsp_err_nxt   = sel_err;
                    rsp_rdata_nxt = (!PWRITE && !sel_err) ? sel_rdata : '0;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (tmo_hit) begin
                        rsp_err_nxt     = 1'b1;
                        rsp_timeout_nxt = 1'b1;
                    end
                end
            end
            ST_DERR: begin
                rsp_valid_nxt = 1'b1;
                rsp_err_nxt   = 1'b1;
                paddr_nxt     = '0;
                pprot_nxt     = '0;
                psel_nxt      = '0;
                penable_nxt   = 1'b0;
                pwrite_nxt    = 1'b0;
                pwdata_nxt    = '0;
                pstrb_nxt     = '0;
            end
            default: ;
        endcase
        if (accept) begin
            paddr_nxt   = cmd_addr;
            pprot_nxt   = cmd_prot;
            pwrite_nxt  = cmd_write;
            pwdata_nxt  = cmd_wdata;
            pstrb_nxt   = cmd_write ? cmd_strb : '0;
            psel_nxt    = cmd_dec;
            penable_nxt = 1'b0;
            cnt_nxt     = '0;
        end
    end

    // Output and counter registers; reset drops any in-flight transfer silently
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            PADDR       <= '0;
            PPROT       <= '0;
            PSEL        <= '0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            cnt         <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            PADDR       <= paddr_nxt;
            PPROT       <= pprot_nxt;
            PSEL        <= psel_nxt;
            PENABLE     <= penable_nxt;
            PWRITE      <= pwrite_nxt;
            PWDATA      <= pwdata_nxt;
            PSTRB       <= pstrb_nxt;
            cnt         <= cnt_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            rsp_err     <= rsp_err_nxt;
            rsp_timeout <= rsp_timeout_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb4_master_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb4_master_mux
//  Description : Directed scoreboard bench for apb4_master_mux; instance A has
//                four slaves, instance B has three for decode-error cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb4_master_mux;

    localparam int AW = 32;
    localparam int DW = 32;

    logic PCLK = 1'b0;
    logic PRESETn;
    always #5 PCLK = ~PCLK;

    // Instance A (4 slaves)
    logic          cmd_valid_a, cmd_ready_a, cmd_write_a;
    logic [AW-1:0] cmd_addr_a;
    logic [DW-1:0] cmd_wdata_a;
    logic [3:0]    cmd_strb_a;
    logic [2:0]    cmd_prot_a;
    logic          rsp_valid_a, rsp_err_a, rsp_timeout_a;
    logic [DW-1:0] rsp_rdata_a;
    logic [AW-1:0] PADDR_a;
    logic [2:0]    PPROT_a;
    logic [3:0]    PSEL_a;
    logic          PENABLE_a, PWRITE_a;
    logic [DW-1:0] PWDATA_a;
    logic [3:0]    PSTRB_a;
    logic [3:0]    PREADY_a, PSLVERR_a;
    logic [4*DW-1:0] PRDATA_a;

    // Instance B (3 slaves)
    logic          cmd_valid_b, cmd_ready_b, cmd_write_b;
    logic [AW-1:0] cmd_addr_b;
    logic [DW-1:0] cmd_wdata_b;
    logic [3:0]    cmd_strb_b;
    logic [2:0]    cmd_prot_b;
    logic          rsp_valid_b, rsp_err_b, rsp_timeout_b;
    logic [DW-1:0] rsp_rdata_b;
    logic [AW-1:0] PADDR_b;
    logic [2:0]    PPROT_b;
    logic [2:0]    PSEL_b;
    logic          PENABLE_b, PWRITE_b;
    logic [DW-1:0] PWDATA_b;
    logic [3:0]    PSTRB_b;
    logic [2:0]    PREADY_b, PSLVERR_b;
    logic [3*DW-1:0] PRDATA_b;

    apb4_master_mux #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(4), .SLV_LSB(12), .TIMEOUT(16)) u_dut_a (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_addr(cmd_addr_a),
        .cmd_write(cmd_write_a), .cmd_wdata(cmd_wdata_a), .cmd_strb(cmd_strb_a), .cmd_prot(cmd_prot_a),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a), .rsp_timeout(rsp_timeout_a),
        .PADDR(PADDR_a), .PPROT(PPROT_a), .PSEL(PSEL_a), .PENABLE(PENABLE_a), .PWRITE(PWRITE_a),
        .PWDATA(PWDATA_a), .PSTRB(PSTRB_a), .PREADY(PREADY_a), .PRDATA(PRDATA_a), .PSLVERR(PSLVERR_a)
    );

    apb4_master_mux #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(3), .SLV_LSB(12), .TIMEOUT(16)) u_dut_b (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_addr(cmd_addr_b),
        .cmd_write(cmd_write_b), .cmd_wdata(cmd_wdata_b), .cmd_strb(cmd_strb_b), .cmd_prot(cmd_prot_b),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .rsp_timeout(rsp_timeout_b),
        .PADDR(PADDR_b), .PPROT(PPROT_b), .PSEL(PSEL_b), .PENABLE(PENABLE_b), .PWRITE(PWRITE_b),
        .PWDATA(PWDATA_b), .PSTRB(PSTRB_b), .PREADY(PREADY_b), .PRDATA(PRDATA_b), .PSLVERR(PSLVERR_b)
    );

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic exp_t mk(input logic [DW-1:0] rd, input logic er, input logic to);
        exp_t e;
        e.rdata = rd;
        e.err   = er;
        e.tmo   = to;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd, input logic [3:0] st);
        cmd_addr_a  = addr;
        cmd_write_a = wr;
        cmd_wdata_a = wd;
        cmd_strb_a  = st;
        cmd_prot_a  = 3'b010;
        cmd_valid_a = 1'b1;
    endtask

    task automatic drive_b(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd, input logic [3:0] st);
        cmd_addr_b  = addr;
        cmd_write_b = wr;
        cmd_wdata_b = wd;
        cmd_strb_b  = st;
        cmd_prot_b  = 3'b001;
        cmd_valid_b = 1'b1;
    endtask

    // Response monitor: pops the scoreboard on every pulse, otherwise rsp_* must be zero
    always @(negedge PCLK) begin
        exp_t e;
        if (rsp_valid_a === 1'b1) begin
            if (q_a.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL rsp_a_unexpected: got rsp_valid=1, expected no response");
            end else begin
                e = q_a.pop_front();
                chk("rsp_a_rdata",   64'(rsp_rdata_a),   64'(e.rdata));
                chk("rsp_a_err",     64'(rsp_err_a),     64'(e.err));
                chk("rsp_a_timeout", 64'(rsp_timeout_a), 64'(e.tmo));
            end
        end else begin
            chk("rsp_a_quiet", 64'({rsp_valid_a, rsp_rdata_a, rsp_err_a, rsp_timeout_a}), 64'h0);
        end
        if (rsp_valid_b === 1'b1) begin
            if (q_b.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL rsp_b_unexpected: got rsp_valid=1, expected no response");
            end else begin
                e = q_b.pop_front();
                chk("rsp_b_rdata",   64'(rsp_rdata_b),   64'(e.rdata));
                chk("rsp_b_err",     64'(rsp_err_b),     64'(e.err));
                chk("rsp_b_timeout", 64'(rsp_timeout_b), 64'(e.tmo));
            end
        end else begin
            chk("rsp_b_quiet", 64'({rsp_valid_b, rsp_rdata_b, rsp_err_b, rsp_timeout_b}), 64'h0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        PRESETn = 1'b0;
        cmd_valid_a = 0; cmd_addr_a = '0; cmd_write_a = 0; cmd_wdata_a = '0; cmd_strb_a = '0; cmd_prot_a = '0;
        cmd_valid_b = 0; cmd_addr_b = '0; cmd_write_b = 0; cmd_wdata_b = '0; cmd_strb_b = '0; cmd_prot_b = '0;
        PREADY_a = '0; PSLVERR_a = '0; PRDATA_a = '0;
        PREADY_b = '0; PSLVERR_b = '0; PRDATA_b = '0;

        // Reset state
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_psel",      64'(PSEL_a),      64'h0);
        chk("rst_penable",   64'(PENABLE_a),   64'h0);
        chk("rst_paddr",     64'(PADDR_a),     64'h0);
        chk("rst_cmd_ready", 64'(cmd_ready_a), 64'h0);
        chk("rst_psel_b",    64'(PSEL_b),      64'h0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;

        // 1: zero-wait write to slave 1
        PREADY_a = 4'b0010;
        drive_a(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 4'hF);
        q_a.push_back(mk(32'h0, 1'b0, 1'b0));
        @(negedge PCLK); chk("t1_ready", 64'(cmd_ready_a), 64'h1);
        @(posedge PCLK); #1; cmd_valid_a = 1'b0;
        @(negedge PCLK);
        chk("t1_setup_psel",    64'(PSEL_a),    64'h2);
        chk("t1_setup_penable", 64'(PENABLE_a), 64'h0);
        chk("t1_paddr",         64'(PADDR_a),   64'h1004);
        chk("t1_pwrite",        64'(PWRITE_a),  64'h1);
        chk("t1_pwdata",        64'(PWDATA_a),  64'hDEAD_BEEF);
        chk("t1_pstrb",         64'(PSTRB_a),   64'hF);
        chk("t1_pprot",         64'(PPROT_a),   64'h2);
        @(negedge PCLK);
        chk("t1_access_penable", 64'(PENABLE_a),   64'h1);
        chk("t1_access_psel",    64'(PSEL_a),      64'h2);
        chk("t1_access_ready",   64'(cmd_ready_a), 64'h1);
        @(negedge PCLK);
        chk("t1_rsp_valid",    64'(rsp_valid_a), 64'h1);
        chk("t1_done_psel",    64'(PSEL_a),      64'h0);
        chk("t1_done_penable", 64'(PENABLE_a),   64'h0);
        @(posedge PCLK); #1;

        // 2: read from slave 3 with three wait states; other slaves ready and erroring
        PREADY_a  = 4'b0111;
        PSLVERR_a = 4'b0001;
        PRDATA_a[3*DW +: DW] = 32'h1234_5678;
        PRDATA_a[1*DW +: DW] = 32'hAAAA_5555;
        drive_a(32'h0000_3000, 1'b0, 32'hFFFF_FFFF, 4'hF);
        q_a.push_back(mk(32'h1234_5678, 1'b0, 1'b0));
        @(negedge PCLK); chk("t2_ready", 64'(cmd_ready_a), 64'h1);
        @(posedge PCLK); #1; cmd_valid_a = 1'b0;
        @(negedge PCLK);
        chk("t2_setup_psel", 64'(PSEL_a),    64'h8);
        chk("t2_pstrb",      64'(PSTRB_a),   64'h0);
        chk("t2_pwrite",     64'(PWRITE_a),  64'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge PCLK);
            chk("t2_penable_held", 64'(PENABLE_a),   64'h1);
            chk("t2_wait_ready",   64'(cmd_ready_a), (k == 3) ? 64'h1 : 64'h0);
            if (k == 2) begin
                @(posedge PCLK); #1;
                PREADY_a = 4'b1111;
            end
        end
        @(negedge PCLK);
        chk("t2_rsp_valid",    64'(rsp_valid_a), 64'h1);
        chk("t2_done_penable", 64'(PENABLE_a),   64'h0);
        @(posedge PCLK); #1;
        PREADY_a = '0; PSLVERR_a = '0;

        // 3: back-to-back write (slave 2) then read (slave 0)
        PREADY_a = 4'b1111;
        PRDATA_a[0*DW +: DW] = 32'hCAFE_F00D;
        drive_a(32'h0000_2008, 1'b1, 32'h1111_2222, 4'b0011);
        q_a.push_back(mk(32'h0, 1'b0, 1'b0));
        @(negedge PCLK); chk("t3_ready1", 64'(cmd_ready_a), 64'h1);
        @(posedge PCLK); #1;
        drive_a(32'h0000_0010, 1'b0, 32'h0, 4'hF);
        q_a.push_back(mk(32'hCAFE_F00D, 1'b0, 1'b0));
        @(negedge PCLK);
        chk("t3_setup1_psel",  64'(PSEL_a),      64'h4);
        chk("t3_setup1_ready", 64'(cmd_ready_a), 64'h0);
        chk("t3_setup1_pstrb", 64'(PSTRB_a),     64'h3);
        @(negedge PCLK);
        chk("t3_access1_penable", 64'(PENABLE_a),   64'h1);
        chk("t3_access1_ready",   64'(cmd_ready_a), 64'h1);
        @(posedge PCLK); #1; cmd_valid_a = 1'b0;
        @(negedge PCLK);
        chk("t3_setup2_psel", 64'(PSEL_a),      64'h1);
        chk("t3_gap_penable", 64'(PENABLE_a),   64'h0);
        chk("t3_rsp1_valid",  64'(rsp_valid_a), 64'h1);
        chk("t3_pwrite2",     64'(PWRITE_a),    64'h0);
        @(negedge PCLK);
        chk("t3_access2_penable", 64'(PENABLE_a), 64'h1);
        @(negedge PCLK);
        chk("t3_rsp2_valid", 64'(rsp_valid_a), 64'h1);
        chk("t3_done_psel",  64'(PSEL_a),      64'h0);
        @(posedge PCLK); #1;

        // 4: slave 0 never ready -> timeout after 16 ACCESS cycles
        PREADY_a = 4'b1110;
        drive_a(32'h0000_0020, 1'b0, 32'h0, 4'hF);
        q_a.push_back(mk(32'h0, 1'b1, 1'b1));
        @(negedge PCLK); chk("t4_ready", 64'(cmd_ready_a), 64'h1);
        @(posedge PCLK); #1; cmd_valid_a = 1'b0;
        @(negedge PCLK); chk("t4_setup_psel", 64'(PSEL_a), 64'h1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if (PENABLE_a === 1'b1) n++;
            else break;
        end
        chk("t4_access_cycles", 64'(n),           64'd16);
        chk("t4_rsp_valid",     64'(rsp_valid_a), 64'h1);
        chk("t4_psel",          64'(PSEL_a),      64'h0);
        @(posedge PCLK); #1;
        PREADY_a = '0;

        // 5: three-slave instance -> decode error, then PSLVERR on slave 2
        drive_b(32'h0000_3000, 1'b0, 32'h0, 4'hF);
        q_b.push_back(mk(32'h0, 1'b1, 1'b0));
        @(negedge PCLK); chk("t5_ready", 64'(cmd_ready_b), 64'h1);
        @(posedge PCLK); #1; cmd_valid_b = 1'b0;
        @(negedge PCLK);
        chk("t5_derr_psel",  64'(PSEL_b),      64'h0);
        chk("t5_derr_ready", 64'(cmd_ready_b), 64'h0);
        chk("t5_derr_early", 64'(rsp_valid_b), 64'h0);
        @(negedge PCLK);
        chk("t5_derr_rsp",   64'(rsp_valid_b), 64'h1);
        chk("t5_derr_psel2", 64'(PSEL_b),      64'h0);
        @(posedge PCLK); #1;
        PREADY_b  = 3'b100;
        PSLVERR_b = 3'b110;
        drive_b(32'h0000_2000, 1'b1, 32'hA5A5_A5A5, 4'hF);
        q_b.push_back(mk(32'h0, 1'b1, 1'b0));
        @(negedge PCLK); chk("t5_ready2", 64'(cmd_ready_b), 64'h1);
        @(posedge PCLK); #1; cmd_valid_b = 1'b0;
        @(negedge PCLK); chk("t5_setup_psel",  64'(PSEL_b),      64'h4);
        @(negedge PCLK); chk("t5_penable",     64'(PENABLE_b),   64'h1);
        @(negedge PCLK); chk("t5_slverr_rsp",  64'(rsp_valid_b), 64'h1);
        @(posedge PCLK); #1;
        PREADY_b = '0; PSLVERR_b = '0;

        // 6: reset during ACCESS drops the transfer; next command runs normally
        PREADY_a = 4'b0000;
        drive_a(32'h0000_1000, 1'b0, 32'h0, 4'hF);
        @(negedge PCLK); chk("t6_ready", 64'(cmd_ready_a), 64'h1);
        @(posedge PCLK); #1; cmd_valid_a = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK); chk("t6_access_penable", 64'(PENABLE_a), 64'h1);
        @(posedge PCLK); #1; PRESETn = 1'b0;
        @(posedge PCLK); #1;
        @(negedge PCLK);
        chk("t6_rst_psel",    64'(PSEL_a),      64'h0);
        chk("t6_rst_penable", 64'(PENABLE_a),   64'h0);
        chk("t6_rst_paddr",   64'(PADDR_a),     64'h0);
        chk("t6_rst_rsp",     64'(rsp_valid_a), 64'h0);
        @(posedge PCLK); #1; PRESETn = 1'b1;
        PREADY_a = 4'b0010;
        drive_a(32'h0000_1000, 1'b1, 32'h0000_0055, 4'b0001);
        q_a.push_back(mk(32'h0, 1'b0, 1'b0));
        @(negedge PCLK); chk("t6_ready2", 64'(cmd_ready_a), 64'h1);
        @(posedge PCLK); #1; cmd_valid_a = 1'b0;
        @(negedge PCLK); chk("t6_setup_psel", 64'(PSEL_a),      64'h2);
        @(negedge PCLK); chk("t6_penable",    64'(PENABLE_a),   64'h1);
        @(negedge PCLK); chk("t6_rsp_valid",  64'(rsp_valid_a), 64'h1);

        repeat (3) @(negedge PCLK);
        chk("queue_a_drained", 64'(q_a.size()), 64'h0);
        chk("queue_b_drained", 64'(q_b.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
